alu_writeback_stage: RTL and testbench

- Execute-to-writeback stage directly downstream of the ALU.
- Each cycle it captures the ALU result and flags (data_result, overflow, isNotEqual, isLessThan) together with the instruction's destination and class.
- Applies the overflow-to-$rstatus rewrite and resolves bne/blt.
- Buffers results in a 2-entry in-order skid FIFO behind a valid/ready handshake, so regfile write or memory stalls never drop an ALU result.

---
 rtl/alu_writeback_stage_if.sv | 47 ++++
 rtl/alu_writeback_stage.sv | 98 +++++++++
 tb/tb_alu_writeback_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_writeback_stage_if.sv
// Handshake bundle between the ALU, the writeback stage and the regfile/memory side.
// Optional ovf_count signal present when ALU_WB_OVF_COUNT_EN is defined.
interface alu_writeback_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_result;
    logic        overflow;
    logic        isNotEqual;
    logic        isLessThan;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [1:0]  in_class;
    logic [1:0]  in_br;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_br_taken;
`ifdef ALU_WB_OVF_COUNT_EN
    logic [15:0] ovf_count;
`endif

    modport master (
`ifdef ALU_WB_OVF_COUNT_EN
        input  ovf_count,
`endif
        output in_valid, data_result, overflow,
        output isNotEqual, isLessThan,
        output in_rd, in_wen, in_class, in_br,
        output out_ready,
        input  in_ready, out_valid,
        input  out_data, out_rd, out_wen, out_br_taken
    );

    modport slave (
`ifdef ALU_WB_OVF_COUNT_EN
        output ovf_count,
`endif
        input  in_valid, data_result, overflow,
        input  isNotEqual, isLessThan,
        input  in_rd, in_wen, in_class, in_br,
        input  out_ready,
        output in_ready, out_valid,
        output out_data, out_rd, out_wen, out_br_taken
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// ALU-to-writeback stage: $rstatus overflow rewrite, branch resolve, 2-entry skid FIFO.
// Optional overflow counter enabled by defining ALU_WB_OVF_COUNT_EN.
module alu_writeback_stage #(
    parameter int RSTATUS_REG = 30,
    parameter int DEPTH       = 2
) (
    input logic clock,
    input logic reset_n,
    alu_writeback_stage_if.slave bus
);
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        br_taken;
    } entry_t;

    localparam logic [1:0] FULL = 2'(DEPTH);

    entry_t     mem [2];
    entry_t     entry;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       ovf_rw;
    logic       is_br;

    assign bus.in_ready  = (count != FULL);
    assign bus.out_valid = (count != 2'd0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign ovf_rw = bus.overflow && (bus.in_class != 2'b11);
    assign is_br  = (bus.in_br == 2'b01) || (bus.in_br == 2'b10);

    always_comb begin
        entry          = '0;
        entry.br_taken = ((bus.in_br == 2'b01) && bus.isNotEqual) ||
                         ((bus.in_br == 2'b10) && bus.isLessThan);
        unique case (1'b1)
            ovf_rw: begin
                entry.rd   = 5'(RSTATUS_REG);
                entry.data = 32'(bus.in_class) + 32'd1;
                entry.wen  = 1'b1;
            end
            default: begin
                entry.rd   = bus.in_rd;
                entry.data = bus.data_result;
                entry.wen  = bus.in_wen && (bus.in_rd != 5'd0);
            end
        endcase
        if (is_br)
            entry.wen = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head is read straight from storage, so outputs hold while stalled.
    assign bus.out_data     = mem[rd_ptr].data;
    assign bus.out_rd       = mem[rd_ptr].rd;
    assign bus.out_wen      = mem[rd_ptr].wen;
    assign bus.out_br_taken = mem[rd_ptr].br_taken;

`ifdef ALU_WB_OVF_COUNT_EN
    logic [15:0] ovf_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ovf_cnt <= 16'd0;
        else if (push && ovf_rw && (ovf_cnt != 16'hFFFF))
            ovf_cnt <= ovf_cnt + 16'd1;
    end

    assign bus.ovf_count = ovf_cnt;
`endif
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage.
// Also checks ovf_count when built with ALU_WB_OVF_COUNT_EN.
module tb_alu_writeback_stage;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    alu_writeback_stage_if bus ();

    alu_writeback_stage #(
        .RSTATUS_REG(30),
        .DEPTH(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic ovf, input logic [4:0] rd,
                         input logic wen, input logic [1:0] cls,
                         input logic [1:0] br, input logic ne,
                         input logic lt);
        bus.in_valid    = v;
        bus.data_result = d;
        bus.overflow    = ovf;
        bus.in_rd       = rd;
        bus.in_wen      = wen;
        bus.in_class    = cls;
        bus.in_br       = br;
        bus.isNotEqual  = ne;
        bus.isLessThan  = lt;
    endtask

    task automatic head(input string tag, input logic [31:0] d,
                        input logic [4:0] rd, input logic wen,
                        input logic br);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, bus.out_data, d);
        check({tag, "_rd"}, 32'(bus.out_rd), 32'(rd));
        check({tag, "_wen"}, 32'(bus.out_wen), 32'(wen));
        check({tag, "_br"}, 32'(bus.out_br_taken), 32'(br));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 32'd0, 0, 5'd0, 0, 2'b11, 2'b00, 0, 0);
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_rd", 32'(bus.out_rd), 32'd0);
        check("rst_out_wen", 32'(bus.out_wen), 32'd0);
        check("rst_out_br", 32'(bus.out_br_taken), 32'd0);
        reset_n = 1'b1;
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // single push, latency of one cycle
        bus.out_ready = 1'b1;
        drive(1, 32'h7, 0, 5'd5, 1, 2'b11, 2'b00, 0, 0);
        step();
        head("single", 32'h7, 5'd5, 1, 0);
        drive(0, 32'd0, 0, 5'd0, 0, 2'b11, 2'b00, 0, 0);
        step();
        check("single_drained", 32'(bus.out_valid), 32'd0);

        // overflow rewrite to $rstatus
        drive(1, 32'h1234, 1, 5'd9, 0, 2'b00, 2'b00, 0, 0);
        step();
        head("ovf_add", 32'd1, 5'd30, 1, 0);
        drive(1, 32'h1234, 1, 5'd9, 1, 2'b01, 2'b00, 0, 0);
        step();
        head("ovf_addi", 32'd2, 5'd30, 1, 0);
        drive(1, 32'h1234, 1, 5'd9, 1, 2'b10, 2'b00, 0, 0);
        step();
        head("ovf_sub", 32'd3, 5'd30, 1, 0);
        drive(0, 32'd0, 0, 5'd0, 0, 2'b11, 2'b00, 0, 0);
        step();
        check("ovf_drained", 32'(bus.out_valid), 32'd0);
`ifdef ALU_WB_OVF_COUNT_EN
        check("ovf_count", 32'(bus.ovf_count), 32'd3);
`endif

        // backpressure: A, B fill, C held upstream
        bus.out_ready = 1'b0;
        drive(1, 32'hA, 0, 5'd1, 1, 2'b11, 2'b00, 0, 0);
        step();
        head("bp_a", 32'hA, 5'd1, 1, 0);
        check("bp_ready_1", 32'(bus.in_ready), 32'd1);
        drive(1, 32'hB, 0, 5'd2, 1, 2'b11, 2'b00, 0, 0);
        step();
        check("bp_ready_full", 32'(bus.in_ready), 32'd0);
        check("bp_hold_a", bus.out_data, 32'hA);
        drive(1, 32'hC, 0, 5'd3, 1, 2'b11, 2'b00, 0, 0);
        step();
        check("bp_still_full", 32'(bus.in_ready), 32'd0);
        check("bp_hold_a2", bus.out_data, 32'hA);
        bus.out_ready = 1'b1;
        step();
        head("bp_b", 32'hB, 5'd2, 1, 0);
        check("bp_ready_again", 32'(bus.in_ready), 32'd1);
        step();
        head("bp_c", 32'hC, 5'd3, 1, 0);
        drive(0, 32'd0, 0, 5'd0, 0, 2'b11, 2'b00, 0, 0);
        step();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // branches, no-check class, $r0 guard
        drive(1, 32'h11, 0, 5'd3, 1, 2'b11, 2'b01, 1, 0);
        step();
        head("bne_taken", 32'h11, 5'd3, 0, 1);
        drive(1, 32'h22, 0, 5'd4, 1, 2'b11, 2'b10, 1, 0);
        step();
        head("blt_not", 32'h22, 5'd4, 0, 0);
        drive(1, 32'h55, 1, 5'd7, 1, 2'b11, 2'b00, 0, 0);
        step();
        head("ovf_nochk", 32'h55, 5'd7, 1, 0);
        drive(1, 32'hDEAD_BEEF, 0, 5'd0, 1, 2'b11, 2'b00, 0, 0);
        step();
        head("r0_guard", 32'hDEAD_BEEF, 5'd0, 0, 0);
        drive(0, 32'd0, 0, 5'd0, 0, 2'b11, 2'b00, 0, 0);
        step();
        check("br_drained", 32'(bus.out_valid), 32'd0);

        // asynchronous reset while full
        bus.out_ready = 1'b0;
        drive(1, 32'h66, 0, 5'd6, 1, 2'b11, 2'b00, 0, 0);
        step();
        drive(1, 32'h77, 0, 5'd7, 1, 2'b11, 2'b00, 0, 0);
        step();
        check("mid_full", 32'(bus.in_ready), 32'd0);
        drive(0, 32'd0, 0, 5'd0, 0, 2'b11, 2'b00, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", bus.out_data, 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        step();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
`ifdef ALU_WB_OVF_COUNT_EN
        check("post_rst_ovf", 32'(bus.ovf_count), 32'd0);
`endif
        drive(1, 32'h88, 0, 5'd8, 1, 2'b11, 2'b00, 0, 0);
        step();
        head("post_rst_push", 32'h88, 5'd8, 1, 0);
        drive(0, 32'd0, 0, 5'd0, 0, 2'b11, 2'b00, 0, 0);
        step();
        check("post_rst_drained", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
